reg_dump_reader: RTL and testbench

REG_DUMP_READER -- requirements
Module: reg_dump_reader

---
 rtl/reg_dump_reader.sv | 116 +++++++++++
 tb/tb_reg_dump_reader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// Streams a range of register-file entries out as valid/ready beats.
// Ports: clk/rst, start/abort, first_idx/last_idx, read_addr/read_data, out_*, busy/done/err.
module reg_dump_reader #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [4:0]            first_idx,
  input  logic [4:0]            last_idx,
  output logic [4:0]            read_addr,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [4:0]            out_index,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    FINISH
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [4:0] cur_idx;
  logic [4:0] last_q;
  logic       err_flag;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = (first_idx <= last_idx) ? FETCH : FINISH;
        end
      end
      FETCH: begin
        state_nx = abort ? FINISH : SEND;
      end
      SEND: begin
        // abort wins even when the beat is taken this cycle
        if (abort) begin
          state_nx = FINISH;
        end else if (out_ready) begin
          state_nx = out_last ? FINISH : FETCH;
        end
      end
      FINISH: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_idx   <= '0;
      last_q    <= '0;
      err_flag  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (first_idx <= last_idx) begin
              cur_idx  <= first_idx;
              last_q   <= last_idx;
              err_flag <= 1'b0;
            end else begin
              err_flag <= 1'b1;
            end
          end
        end
        FETCH: begin
          out_data  <= read_data;
          out_index <= cur_idx;
          out_last  <= (cur_idx == last_q);
          if (abort) begin
            err_flag <= 1'b1;
          end
        end
        SEND: begin
          // out_last stops the walk, so cur_idx never wraps past 31
          if (abort) begin
            err_flag <= 1'b1;
          end else if (out_ready && !out_last) begin
            cur_idx <= cur_idx + 5'd1;
          end
        end
        FINISH: begin
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign read_addr = cur_idx;
  assign out_valid = (state == SEND);
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);
  assign err       = (state == FINISH) && err_flag;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: directed dumps checked against a range-walk model.
// The model predicts beats from index range, register contents and handshakes.
module tb_reg_dump_reader;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [4:0]    first_idx;
  logic [4:0]    last_idx;
  logic [4:0]    read_addr;
  logic [DW-1:0] read_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [4:0]    out_index;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          err;

  logic [DW-1:0] rf [32];

  int n_chk = 0;
  int n_err = 0;

  logic          known = 1'b0;
  logic          m_active = 1'b0;
  logic          m_fetch = 1'b0;
  logic          e_done = 1'b0;
  logic          e_err = 1'b0;
  logic [4:0]    m_cur = '0;
  logic [4:0]    m_last = '0;
  logic [4:0]    h_idx = '0;
  logic          h_last = 1'b0;
  logic [DW-1:0] h_data = '0;
  int            beats = 0;
  logic          seen_done = 1'b0;
  logic          seen_err = 1'b0;

  always #5 clk = ~clk;

  assign read_data = (read_addr == 5'd0) ? '0 : rf[read_addr];

  reg_dump_reader #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .first_idx (first_idx),
    .last_idx  (last_idx),
    .read_addr (read_addr),
    .read_data (read_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rfv(input logic [4:0] i);
    return (i == 5'd0) ? '0 : rf[i];
  endfunction

  // One cycle: compare at negedge, advance model, then pass the edge.
  task automatic step();
    logic n_done;
    logic n_err_f;
    @(negedge clk);
    seen_done = done;
    seen_err  = err;
    if (known) begin
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("busy", busy, m_active || e_done);
      chk("read_addr", read_addr, m_cur);
      chk("out_valid", out_valid, m_active && !m_fetch);
      if (m_active && !m_fetch) begin
        chk("out_index", out_index, h_idx);
        chk("out_last", out_last, h_last);
        chk("out_data", out_data, h_data);
      end
    end
    n_done  = 1'b0;
    n_err_f = 1'b0;
    if (rst) begin
      known    = 1'b1;
      m_active = 1'b0;
      m_fetch  = 1'b0;
      m_cur    = '0;
    end else if (!m_active && !e_done) begin
      if (start) begin
        if (first_idx <= last_idx) begin
          m_active = 1'b1;
          m_fetch  = 1'b1;
          m_cur    = first_idx;
          m_last   = last_idx;
        end else begin
          n_done  = 1'b1;
          n_err_f = 1'b1;
        end
      end
    end else if (m_active) begin
      if (m_fetch) begin
        m_fetch = 1'b0;
        h_idx   = m_cur;
        h_last  = (m_cur == m_last);
        h_data  = rfv(m_cur);
        if (abort) begin
          m_active = 1'b0;
          n_done   = 1'b1;
          n_err_f  = 1'b1;
        end
      end else begin
        if (out_ready) begin
          beats++;
        end
        if (abort) begin
          m_active = 1'b0;
          n_done   = 1'b1;
          n_err_f  = 1'b1;
        end else if (out_ready) begin
          if (m_cur == m_last) begin
            m_active = 1'b0;
            n_done   = 1'b1;
          end else begin
            m_cur   = m_cur + 5'd1;
            m_fetch = 1'b1;
          end
        end
      end
    end
    e_done = n_done;
    e_err  = n_err_f;
    @(posedge clk);
    #2;
  endtask

  task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
    first_idx = f;
    last_idx  = l;
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (1) begin
      step();
      k++;
      if (seen_done) break;
      if (k >= 100) begin
        n_chk++;
        n_err++;
        $display("FAIL wait_done: got no done after %0d cycles expected done", k);
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int b0;
    int g;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b1;
    first_idx = '0;
    last_idx  = '0;
    for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + DW'(i);
    rf[1]  = 64'h11;
    rf[2]  = 64'h22;
    rf[3]  = 64'h33;
    rf[4]  = 64'h44;
    rf[5]  = 64'h55;
    rf[29] = 64'hDEAD_0029;
    rf[30] = 64'hDEAD_0030;
    rf[31] = 64'hDEAD_0031;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_read_addr", read_addr, 0);

    // x0..x3 with ready held high
    b0 = beats;
    start_dump(5'd0, 5'd3);
    wait_done(k);
    chk("t1_latency", k, 9);
    chk("t1_err", seen_err, 0);
    chk("t1_beats", beats - b0, 4);
    chk("t1_last_data", out_data, 64'h33);
    chk("t1_last_index", out_index, 3);

    // single beat with a stalled consumer
    out_ready = 1'b0;
    b0 = beats;
    start_dump(5'd5, 5'd5);
    repeat (5) step();
    chk("t2_valid", out_valid, 1);
    chk("t2_index", out_index, 5);
    chk("t2_last", out_last, 1);
    chk("t2_data", out_data, 64'h55);
    out_ready = 1'b1;
    wait_done(k);
    chk("t2_latency", 5 + k, 7);
    chk("t2_beats", beats - b0, 1);

    // reversed range is rejected
    b0 = beats;
    start_dump(5'd7, 5'd3);
    wait_done(k);
    chk("t3_latency", k, 1);
    chk("t3_err", seen_err, 1);
    chk("t3_beats", beats - b0, 0);

    // abort while idle does nothing
    abort = 1'b1;
    step();
    step();
    abort = 1'b0;

    // top of the file, plus a start while busy
    b0 = beats;
    start_dump(5'd29, 5'd31);
    step();
    first_idx = 5'd0;
    last_idx  = 5'd1;
    start     = 1'b1;
    step();
    start     = 1'b0;
    wait_done(k);
    chk("t4_latency", 2 + k, 7);
    chk("t4_beats", beats - b0, 3);
    chk("t4_err", seen_err, 0);
    repeat (3) step();
    chk("t4_read_addr", read_addr, 31);

    // abort after the second handshake
    b0 = beats;
    start_dump(5'd1, 5'd10);
    g = 0;
    while ((beats - b0) < 2 && g < 50) begin
      step();
      g++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("t5_done", seen_done, 1);
    chk("t5_err", seen_err, 1);
    chk("t5_beats", beats - b0, 2);
    b0 = beats;
    start_dump(5'd0, 5'd0);
    wait_done(k);
    chk("t5_restart_latency", k, 3);
    chk("t5_restart_err", seen_err, 0);
    chk("t5_restart_beats", beats - b0, 1);

    // abort coincident with a handshake
    b0 = beats;
    start_dump(5'd2, 5'd4);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    chk("t6_done_err", {seen_done, seen_err}, 2'b11);
    chk("t6_beats", beats - b0, 1);

    // register write during SEND, then reset mid-dump
    out_ready = 1'b0;
    start_dump(5'd4, 5'd6);
    step();
    rf[4] = 64'hAA;
    step();
    step();
    chk("t7_data_held", out_data, 64'h44);
    chk("t7_index", out_index, 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t7_rst_valid", out_valid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_done", done, 0);
    out_ready = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
